// File: rtl/stub_page_writer_pkg.sv
// Shared types and width helpers for the paged event memory write front end.
package stub_page_writer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } state_e;

  localparam int unsigned NENT_W = 5;

  // Address bits needed to index depth entries.
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned n;
    n = 0;
    for (int unsigned d = depth - 1; d > 0; d = d >> 1) begin
      n++;
    end
    return n;
  endfunction

  function automatic int unsigned page_w(input int unsigned pages);
    return pages / 2 + 1;
  endfunction

endpackage

// File: rtl/stub_page_writer_page_entry_counter.sv
// Open-page index and saturating per-page entry count; advance closes the page
// and may carry the same-cycle accept into the freshly opened page.
module stub_page_writer_page_entry_counter
  import stub_page_writer_pkg::*;
#(
  parameter int unsigned PAGES   = 2,
  parameter int unsigned MAX_ENT = 31,
  parameter int unsigned PAGE_W  = page_w(PAGES)
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              advance,
  input  logic              accept,
  output logic [PAGE_W-1:0] page,
  output logic [NENT_W-1:0] count,
  output logic              full
);

  localparam logic [NENT_W-1:0] MaxCount = NENT_W'(MAX_ENT);
  localparam logic [PAGE_W-1:0] LastPage = PAGE_W'(PAGES - 1);

  logic [PAGE_W-1:0] page_q, page_d;
  logic [NENT_W-1:0] count_q, count_d;

  always_comb begin
    page_d  = page_q;
    count_d = count_q;
    if (advance) begin
      page_d  = (page_q == LastPage) ? '0 : page_q + PAGE_W'(1);
      count_d = accept ? NENT_W'(1) : '0;
    end else if (accept && (count_q != MaxCount)) begin
      count_d = count_q + NENT_W'(1);
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      page_q  <= '0;
      count_q <= '0;
    end else begin
      page_q  <= page_d;
      count_q <= count_d;
    end
  end

  assign page  = page_q;
  assign count = count_q;
  assign full  = (count_q == MaxCount);

endmodule

// File: rtl/stub_page_writer.sv
// Write-side front end for the paged event memory: splits the input stream into
// events, assigns pages round-robin and drives the memory write port.
module stub_page_writer
  import stub_page_writer_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 18,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned PAGES     = 2,
  parameter int unsigned MAX_ENT   = 31,
  localparam int unsigned ADDR_W   = clogb2(RAM_DEPTH),
  localparam int unsigned PAGE_W   = page_w(PAGES)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 bx_start,
  input  logic [RAM_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [ADDR_W-1:0]    addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 wea,
  output logic [PAGE_W-1:0]    pagea,
  output logic [NENT_W-1:0]    nent_live,
  output logic [NENT_W-1:0]    nent_done,
  output logic [PAGE_W-1:0]    done_page,
  output logic                 page_done,
  output logic                 overflow
);

  state_e state_q, state_d;

  logic              accept, advance, drop, full;
  logic [PAGE_W-1:0] page;
  logic [NENT_W-1:0] count;

  logic                 wea_q, wea_d;
  logic [ADDR_W-1:0]    addra_q, addra_d;
  logic [RAM_WIDTH-1:0] dina_q, dina_d;
  logic [NENT_W-1:0]    nent_done_q, nent_done_d;
  logic [PAGE_W-1:0]    done_page_q, done_page_d;
  logic                 page_done_q, page_done_d;
  logic                 overflow_q, overflow_d;

  stub_page_writer_page_entry_counter #(
    .PAGES   (PAGES),
    .MAX_ENT (MAX_ENT),
    .PAGE_W  (PAGE_W)
  ) u_page_entry_counter (
    .clka    (clka),
    .rsta_n  (rsta_n),
    .advance (advance),
    .accept  (accept),
    .page    (page),
    .count   (count),
    .full    (full)
  );

  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    case (state_q)
      StIdle: if (bx_start) state_d = StFill;
      // A start strobe always opens an empty page, so its word is never refused.
      StFill: din_ready = bx_start | ~full;
      default: state_d = StIdle;
    endcase
  end

  assign accept  = din_valid & din_ready;
  assign advance = (state_q == StFill) & bx_start;
  assign drop    = (state_q == StFill) & din_valid & ~din_ready;

  always_comb begin
    wea_d       = accept;
    addra_d     = addra_q;
    dina_d      = dina_q;
    page_done_d = advance;
    nent_done_d = nent_done_q;
    done_page_d = done_page_q;
    overflow_d  = overflow_q | drop;
    if (accept) begin
      addra_d = advance ? '0 : ADDR_W'(count);
      dina_d  = din;
    end
    if (advance) begin
      nent_done_d = count;
      done_page_d = page;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q     <= StIdle;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      nent_done_q <= '0;
      done_page_q <= '0;
      page_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      nent_done_q <= nent_done_d;
      done_page_q <= done_page_d;
      page_done_q <= page_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign pagea     = page;
  assign nent_live = count;
  assign nent_done = nent_done_q;
  assign done_page = done_page_q;
  assign page_done = page_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_stub_page_writer.sv
// Directed bench for stub_page_writer: vector table plus hand-built overflow and
// mid-event reset sequences.
module tb_stub_page_writer;

  localparam int unsigned RW = 18;
  localparam int unsigned AW = 10;
  localparam int unsigned PW = 2;

  typedef struct {
    logic          bx;
    logic          vld;
    logic [RW-1:0] din;
    logic          rdy;
    logic          wea;
    logic [AW-1:0] addra;
    logic [RW-1:0] dina;
    logic [PW-1:0] pagea;
    logic [4:0]    live;
    logic [4:0]    ndone;
    logic [PW-1:0] dpage;
    logic          pdone;
    logic          ovf;
  } vec_t;

  logic          clka;
  logic          rsta_n;
  logic          bx_start;
  logic [RW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] addra;
  logic [RW-1:0] dina;
  logic          wea;
  logic [PW-1:0] pagea;
  logic [4:0]    nent_live;
  logic [4:0]    nent_done;
  logic [PW-1:0] done_page;
  logic          page_done;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  stub_page_writer dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .bx_start  (bx_start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .addra     (addra),
    .dina      (dina),
    .wea       (wea),
    .pagea     (pagea),
    .nent_live (nent_live),
    .nent_done (nent_done),
    .done_page (done_page),
    .page_done (page_done),
    .overflow  (overflow)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  function automatic vec_t mk(input int bx, input int vld, input int d, input int rdy,
                              input int we, input int ad, input int da, input int pg,
                              input int live, input int nd, input int dp, input int pd,
                              input int ov);
    vec_t v;
    v.bx = 1'(bx);     v.vld = 1'(vld);    v.din = RW'(d);
    v.rdy = 1'(rdy);   v.wea = 1'(we);     v.addra = AW'(ad);
    v.dina = RW'(da);  v.pagea = PW'(pg);  v.live = 5'(live);
    v.ndone = 5'(nd);  v.dpage = PW'(dp);  v.pdone = 1'(pd);
    v.ovf = 1'(ov);
    return v;
  endfunction

  // Write address and data are only meaningful on a write cycle.
  task automatic check(input vec_t e, input string name);
    logic ok;
    n_tests++;
    ok = (din_ready === e.rdy) && (wea === e.wea) && (pagea === e.pagea) &&
         (nent_live === e.live) && (nent_done === e.ndone) && (done_page === e.dpage) &&
         (page_done === e.pdone) && (overflow === e.ovf);
    if (e.wea) ok = ok && (addra === e.addra) && (dina === e.dina);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b wea=%b addra=%0d dina=%h pagea=%0d live=%0d ndone=%0d dpage=%0d pdone=%b ovf=%b; required rdy=%b wea=%b addra=%0d dina=%h pagea=%0d live=%0d ndone=%0d dpage=%0d pdone=%b ovf=%b",
               name, din_ready, wea, addra, dina, pagea, nent_live, nent_done, done_page,
               page_done, overflow, e.rdy, e.wea, e.addra, e.dina, e.pagea, e.live,
               e.ndone, e.dpage, e.pdone, e.ovf);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then check that cycle's outputs.
  task automatic step(input vec_t e, input string name);
    @(negedge clka);
    bx_start  = e.bx;
    din_valid = e.vld;
    din       = e.din;
    #1 check(e, name);
  endtask

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsta_n    = 1'b0;
    bx_start  = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    #3 check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_state");
    @(negedge clka);
    rsta_n = 1'b1;

    //             bx vld din     rdy wea ad dina    pg live nd dp pd ov
    tbl[0]  = mk(0, 1, 'h111, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 'h222, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 'h0a,  1, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 'h0b,  1, 1, 0, 'h0a,  0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 'h0c,  1, 1, 1, 'h0b,  0, 2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,     1, 1, 2, 'h0c,  0, 3, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0,     1, 0, 0, 0,     0, 3, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,     1, 0, 0, 0,     1, 0, 3, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0,     1, 0, 0, 0,     1, 0, 3, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,     1, 0, 0, 0,     0, 0, 0, 1, 1, 0);
    tbl[11] = mk(0, 1, 'h11,  1, 0, 0, 0,     0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 'h12,  1, 1, 0, 'h11,  0, 1, 0, 1, 0, 0);
    tbl[13] = mk(1, 1, 'h3d,  1, 1, 1, 'h12,  0, 2, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 0,     1, 1, 0, 'h3d,  1, 1, 2, 0, 1, 0);
    tbl[15] = mk(0, 0, 0,     1, 0, 0, 0,     1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Close page 1 (one entry), then stream 33 words into page 0.
    step(mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0), "ovf_start");
    for (int i = 0; i < 33; i++) begin
      step(mk(0, 1, 'h100 + i, (i < 31) ? 1 : 0, (i >= 1 && i <= 31) ? 1 : 0, i - 1,
              'h100 + i - 1, 0, (i < 31) ? i : 31, 1, 1, (i == 0) ? 1 : 0,
              (i >= 32) ? 1 : 0), $sformatf("ovf_word[%0d]", i));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 1, 1, 0, 1), "ovf_hold");
    step(mk(1, 0, 0, 1, 0, 0, 0, 0, 31, 1, 1, 0, 1), "ovf_close");
    step(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 31, 0, 1, 0), "ovf_done");

    // Five words into page 1, then reset mid-event.
    for (int j = 0; j < 5; j++) begin
      step(mk(0, 1, 'h200 + j, 1, (j >= 1) ? 1 : 0, j - 1, 'h200 + j - 1, 1, j, 31, 0, 0, 0),
           $sformatf("pre_rst[%0d]", j));
    end
    step(mk(0, 0, 0, 1, 1, 4, 'h204, 1, 5, 31, 0, 0, 0), "pre_rst_live5");
    @(negedge clka);
    din_valid = 1'b1;
    din       = RW'('h3ff);
    #2 rsta_n = 1'b0;
    #1 check(mk(0, 1, 'h3ff, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "async_reset");
    @(negedge clka);
    rsta_n = 1'b1;
    step(mk(0, 1, 'h3aa, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_ignored0");
    step(mk(0, 1, 'h3ab, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_ignored1");
    step(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_start");
    step(mk(0, 1, 'h2ab, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_no_pdone");
    step(mk(0, 0, 0,     1, 1, 0, 'h2ab, 0, 1, 0, 0, 0, 0), "post_rst_write");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stub_page_writer.md
Name: stub_page_writer

Overview:
- Write-side front end for the paged event memory.
- Accepts a valid/ready stream of data words, split into events by a start-of-event strobe.
- Assigns each event to a memory page round-robin and generates the write address, write data, write enable and page select for the memory's write port.
- Counts entries per page and publishes the final count of each closed page to the downstream read side.

Parameters:
- RAM_WIDTH, 18: data word width; equals the memory's RAM_WIDTH.
- RAM_DEPTH, 1024: entries per page; sets the addra width to clogb2(RAM_DEPTH).
- PAGES, 2: number of pages; pagea width is PAGES/2+1.
- MAX_ENT, 31: maximum entries accepted per page; must be ≤31 (5-bit count) and ≤RAM_DEPTH.

Ports:
- clka  in  1  single clock; also drives the memory write clock.
- rsta_n  in  1  asynchronous, active-low reset.
- bx_start  in  1  start of a new event; closes the current page and opens the next.
- din  in  RAM_WIDTH  incoming data word.
- din_valid  in  1  din is valid.
- din_ready  out  1  writer can accept din this cycle.
- addra  out  clogb2(RAM_DEPTH)  memory write address within the page.
- dina  out  RAM_WIDTH  memory write data.
- wea  out  1  memory write enable.
- pagea  out  PAGES/2+1  memory write page.
- nent_live  out  5  entries written so far to the open page.
- nent_done  out  5  final entry count of the most recently closed page.
- done_page  out  PAGES/2+1  index of the most recently closed page.
- page_done  out  1  one-cycle strobe: nent_done and done_page were updated this cycle.
- overflow  out  1  sticky per open page: a word was dropped because the page was full.

Behaviour:
- Reset (async assert, sync release): state IDLE; din_ready=0; wea=0; addra=0; dina=0; pagea=0; nent_live=0; nent_done=0; done_page=0; page_done=0; overflow=0.
- State IDLE: din_ready=0 and din is ignored. On bx_start, go to FILL with open page 0 and count 0. No page_done is issued on this first start.
- State FILL: din_ready=1 while count<MAX_ENT. An accept is din_valid && din_ready.
- Accept timing: on an accept in cycle N, in cycle N+1 wea=1, addra=count, dina=din, pagea=open page; count and nent_live increment in cycle N+1. Latency is one cycle and wea is registered. With no accept, wea=0 in the next cycle.
- Page full: when count==MAX_ENT, din_ready=0. A din_valid while full drops the word and sets overflow=1. overflow stays set until the next bx_start.
- bx_start in FILL: in the next cycle,
  - page_done=1;
  - nent_done = final count of the closing page, including any accept in the cycle before bx_start;
  - done_page = closing page;
  - open page = (page+1) mod PAGES; count, nent_live and overflow cleared to 0.
- bx_start with din_valid in the same cycle: the word belongs to the new page. It is written at addra=0 of the new page, and in the following cycle nent_live=1 and count=1. din_ready is 1 in the bx_start cycle regardless of the old page's fill.
- Page wrap: the page index wraps from PAGES-1 to 0. There is no back-pressure from the reader; page reuse after PAGES events is the system's contract.
- Back-to-back bx_start: each strobe closes a page. An empty page closes with nent_done=0.
- Reset mid-event: all state is cleared immediately, with no page_done for the aborted page, and the block re-enters IDLE.
- Width rules: count is 5 bits and never exceeds MAX_ENT, so it never wraps. addra is count zero-extended to the addra width.

Decomposition:
- Shared package:
  - state encoding (IDLE, FILL);
  - NENT_W=5;
  - clogb2 function;
  - page index width derived from PAGES.
- One natural sub-module, page_entry_counter: the open-page index plus the 5-bit count, with clear-on-bx_start, increment-on-accept and saturation at MAX_ENT. The FSM, output registers and strobes stay in the top module.

Test Plan:
- Reset, then bx_start, then 3 consecutive valid words A, B, C → wea high for 3 cycles, starting one cycle after each accept, with addra 0, 1, 2 and pagea=0 → nent_live=3.
- A second bx_start after those 3 words → page_done pulse with nent_done=3, done_page=0; pagea=1, nent_live=0. A third bx_start → done_page=1, pagea wraps to 0.
- 33 consecutive valid words in one event → 31 writes at addra 0..30; din_ready falls after the 31st accept; overflow=1. The next bx_start gives nent_done=31 and overflow cleared.
- bx_start and din_valid with word D in the same cycle, after a page holding 2 words → nent_done=2; D written at addra=0 of the new page; nent_live=1.
- Data before the first bx_start → din_ready=0, no wea, nent_live stays 0.
- rsta_n low mid-event with 5 entries written → all outputs are 0 asynchronously; no page_done; after release, data is ignored until bx_start.
